// File: rtl/step_counter_pkg.sv
// Shared mode encodings and direction constants for the step counter.
// STEP_COUNTER_SAT_EN enables the saturate mode in step_counter_next.
package step_counter_pkg;

    typedef enum logic [1:0] {
        WRAP   = 2'b00,
        SAT    = 2'b01,
        BOUNCE = 2'b10
    } mode_e;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-state logic: next count, crossing pulses and next direction.
// Saturate clamping exists only when STEP_COUNTER_SAT_EN is defined; otherwise mode 01 wraps.
module step_counter_next
    import step_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STEP_W = 3
) (
    input  logic              load,
    input  logic              enable,
    input  logic              direction,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] value,
    input  logic [WIDTH-1:0]  limit,
    input  logic [WIDTH-1:0]  I,
    input  logic [WIDTH-1:0]  count,
    input  logic              dir,
    output logic [WIDTH-1:0]  count_next,
    output logic              dir_next,
    output logic              ovf_next,
    output logic              unf_next
);

    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   lim_x;
    logic [WIDTH:0]   val_x;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             bounce;
    logic             up;
`ifdef STEP_COUNTER_SAT_EN
    logic             sat;
    assign sat = (mode == SAT);
`endif

    assign cnt_x  = {1'b0, count};
    assign lim_x  = {1'b0, limit};
    assign val_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, value};
    assign sum    = cnt_x + val_x;
    assign diff   = count - val_x[WIDTH-1:0];
    assign bounce = (mode == BOUNCE);
    // Bounce walks by its own direction register; other modes follow the input.
    assign up     = bounce ? dir : direction;

    always_comb begin
        count_next = count;
        dir_next   = dir;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (!load) begin
            count_next = (I > limit) ? limit : I;
            dir_next   = direction;
        end else if (enable) begin
            if (!bounce) dir_next = direction;
            // A lowered limit costs one enabled cycle of plain clamping.
            if (count > limit) begin
                count_next = limit;
            end else if (value != '0) begin
                if (up) begin
                    if (sum > lim_x) begin
                        ovf_next = 1'b1;
                        if (bounce) begin
                            count_next = limit;
                            dir_next   = ~dir;
                        end
`ifdef STEP_COUNTER_SAT_EN
                        else if (sat) begin
                            count_next = limit;
                        end
`endif
                        else begin
                            count_next = '0;
                        end
                    end else begin
                        count_next = sum[WIDTH-1:0];
                        if (bounce && (sum == lim_x)) dir_next = ~dir;
                    end
                end else begin
                    if (val_x > cnt_x) begin
                        unf_next = 1'b1;
                        if (bounce) begin
                            count_next = '0;
                            dir_next   = ~dir;
                        end
`ifdef STEP_COUNTER_SAT_EN
                        else if (sat) begin
                            count_next = '0;
                        end
`endif
                        else begin
                            count_next = limit;
                        end
                    end else begin
                        count_next = diff;
                        if (bounce && (diff == '0)) dir_next = ~dir;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/step_counter.sv
// Step counter top: registers for count, direction and crossing pulses.
// Optional saturate mode is selected at build time with STEP_COUNTER_SAT_EN.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STEP_W = 3
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              load,
    input  logic              enable,
    input  logic              direction,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] value,
    input  logic [WIDTH-1:0]  limit,
    input  logic [WIDTH-1:0]  I,
    output logic [WIDTH-1:0]  Output,
    output logic              ovf,
    output logic              unf,
    output logic              at_max,
    output logic              at_min,
    output logic              dir_q
);

    logic [WIDTH-1:0] count_next;
    logic             dir_next;
    logic             ovf_next;
    logic             unf_next;

    step_counter_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .load       (load),
        .enable     (enable),
        .direction  (direction),
        .mode       (mode),
        .value      (value),
        .limit      (limit),
        .I          (I),
        .count      (Output),
        .dir        (dir_q),
        .count_next (count_next),
        .dir_next   (dir_next),
        .ovf_next   (ovf_next),
        .unf_next   (unf_next)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            Output <= '0;
            dir_q  <= UP;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            Output <= count_next;
            dir_q  <= dir_next;
            ovf    <= ovf_next;
            unf    <= unf_next;
        end
    end

    assign at_max = (Output == limit);
    assign at_min = (Output == '0);

endmodule

// File: tb/tb_step_counter.sv
// Directed self-checking bench for step_counter with hand-computed expectations.
// Saturate expectations follow STEP_COUNTER_SAT_EN as defined for the build.
module tb_step_counter;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STEP_W = 3;

    logic              clock;
    logic              clear;
    logic              load;
    logic              enable;
    logic              direction;
    logic [1:0]        mode;
    logic [STEP_W-1:0] value;
    logic [WIDTH-1:0]  limit;
    logic [WIDTH-1:0]  i_data;
    logic [WIDTH-1:0]  out_w;
    logic              ovf;
    logic              unf;
    logic              at_max;
    logic              at_min;
    logic              dir_q;

    int pass_cnt  = 0;
    int total_cnt = 0;

    step_counter #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .load      (load),
        .enable    (enable),
        .direction (direction),
        .mode      (mode),
        .value     (value),
        .limit     (limit),
        .I         (i_data),
        .Output    (out_w),
        .ovf       (ovf),
        .unf       (unf),
        .at_max    (at_max),
        .at_min    (at_min),
        .dir_q     (dir_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Bounce, limit 5, start 0 upward, step 2.
    logic [WIDTH-1:0] b_out [7] = '{16'd2, 16'd4, 16'd5, 16'd3, 16'd1, 16'd0, 16'd2};
    logic             b_ovf [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic             b_unf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic             b_dir [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        clear     = 1'b0;
        load      = 1'b1;
        enable    = 1'b0;
        direction = 1'b1;
        mode      = 2'b00;
        value     = '0;
        limit     = 16'hFFFF;
        i_data    = '0;

        #12;
        check("reset_out", out_w, 0);
        check("reset_dir", dir_q, 1);
        check("reset_ovf", ovf, 0);
        check("reset_unf", unf, 0);
        check("reset_at_min", at_min, 1);

        // Load 0x0123 downward, then assert clear between edges.
        clear = 1'b1; load = 1'b0; i_data = 16'h0123; direction = 1'b0; enable = 1'b1;
        value = 3'd1;
        tick();
        check("load_0123", out_w, 16'h0123);
        check("load_dir0", dir_q, 0);
        load = 1'b1;
        tick();
        check("count_down_0122", out_w, 16'h0122);
        #2 clear = 1'b0;
        #1;
        check("async_clear_out", out_w, 0);
        check("async_clear_dir", dir_q, 1);
        tick();
        check("held_in_clear", out_w, 0);
        #2 clear = 1'b1; direction = 1'b1;
        tick();
        check("resume_from_0", out_w, 1);

        // Hold and zero step.
        enable = 1'b0;
        tick();
        check("hold_out", out_w, 1);
        check("hold_ovf", ovf, 0);
        enable = 1'b1; value = 3'd0;
        tick();
        check("step0_out", out_w, 1);

        // Wrap up-crossing.
        limit = 16'd10; mode = 2'b00; load = 1'b0; i_data = 16'd9; direction = 1'b1; value = 3'd3;
        tick();
        check("wrap_load9", out_w, 9);
        load = 1'b1;
        tick();
        check("wrap_up_out", out_w, 0);
        check("wrap_up_ovf", ovf, 1);
        tick();
        check("wrap_up_next", out_w, 3);
        check("wrap_ovf_one_cycle", ovf, 0);

        // Wrap down-crossing.
        load = 1'b0; i_data = 16'd1; direction = 1'b0;
        tick();
        check("wrap_load1", out_w, 1);
        load = 1'b1;
        tick();
        check("wrap_dn_out", out_w, 10);
        check("wrap_dn_unf", unf, 1);
        check("wrap_dn_at_max", at_max, 1);
        tick();
        check("wrap_dn_next", out_w, 7);
        check("wrap_unf_one_cycle", unf, 0);

        // Mode 01 near full scale.
        limit = 16'hFFFF; mode = 2'b01; load = 1'b0; i_data = 16'hFFFE; direction = 1'b1;
        value = 3'd7;
        tick();
        load = 1'b1;
        tick();
`ifdef STEP_COUNTER_SAT_EN
        check("sat_up_out", out_w, 16'hFFFF);
`else
        check("sat_off_wraps", out_w, 0);
`endif
        check("sat_up_ovf", ovf, 1);

        // Bounce sequence.
        mode = 2'b10; limit = 16'd5; load = 1'b0; i_data = 16'd0; direction = 1'b1; value = 3'd2;
        tick();
        check("bounce_load", out_w, 0);
        load = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("bounce_out_%0d", k), out_w, b_out[k]);
            check($sformatf("bounce_ovf_%0d", k), ovf, b_ovf[k]);
            check($sformatf("bounce_unf_%0d", k), unf, b_unf[k]);
            check($sformatf("bounce_dir_%0d", k), dir_q, b_dir[k]);
        end

        // Bounce landing exactly on limit turns around without a pulse.
        limit = 16'd4; load = 1'b0; i_data = 16'd0; direction = 1'b1;
        tick();
        load = 1'b1;
        tick();
        tick();
        check("land_out", out_w, 4);
        check("land_ovf", ovf, 0);
        check("land_dir", dir_q, 0);
        tick();
        check("land_after", out_w, 2);

        // Load outranks counting and clamps to limit.
        mode = 2'b00; limit = 16'd15; load = 1'b0; enable = 1'b1; i_data = 16'd20;
        value = 3'd3; direction = 1'b1;
        tick();
        check("load_clamp_out", out_w, 15);
        check("load_clamp_ovf", ovf, 0);
        check("load_clamp_at_max", at_max, 1);

        // Lowered limit: one clamp cycle, then normal stepping.
        i_data = 16'd12;
        tick();
        check("load12", out_w, 12);
        load = 1'b1; limit = 16'd8; value = 3'd1;
        tick();
        check("limit_clamp_out", out_w, 8);
        check("limit_clamp_ovf", ovf, 0);
        tick();
        check("after_clamp_wrap", out_w, 0);
        check("after_clamp_ovf", ovf, 1);
        tick();
        check("after_clamp_step", out_w, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
